// File: rtl/obi_cache_master.sv
`default_nettype none
// ============================================================================
// Module   : obi_cache_master
// Purpose  : OBI initiator driving the key/value cache responder. Accepts one
//            command on a valid/ready port, writes the {op,key,value} frame to
//            the cache as OBI word writes (operation word last, since that
//            write triggers the cache), reads the value back and returns it
//            with error/timeout status on a valid/ready response port.
//            Exactly one OBI transaction is outstanding at any time.
// Ports    : clk, rst_n (async, active-low)
//            cmd_valid/cmd_ready/cmd_op/cmd_key/cmd_value : command port
//            rsp_valid/rsp_ready/rsp_value/rsp_err/rsp_timeout : response
//            obi_req/obi_we/obi_be/obi_addr/obi_wdata/obi_rready : OBI request
//              fields (req, we, be, addr, wdata, rready of obi_req_t)
//            obi_gnt/obi_rvalid/obi_rdata/obi_err : OBI response fields
//              (gnt, rvalid, rdata, err of obi_rsp_t)
// Revision : 1.0 - initial release
// ============================================================================
module obi_cache_master #(
  parameter int ARCHITECTURE   = 32,
  parameter int KEY_WIDTH      = 29,
  parameter int VALUE_WIDTH    = 64,
  parameter int OP_WIDTH       = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // command port
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [OP_WIDTH-1:0]       cmd_op,
  input  logic [KEY_WIDTH-1:0]      cmd_key,
  input  logic [VALUE_WIDTH-1:0]    cmd_value,
  // response port
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [VALUE_WIDTH-1:0]    rsp_value,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  // OBI request
  output logic                      obi_req,
  output logic                      obi_we,
  output logic [ARCHITECTURE/8-1:0] obi_be,
  output logic [ARCHITECTURE-1:0]   obi_addr,
  output logic [ARCHITECTURE-1:0]   obi_wdata,
  output logic                      obi_rready,
  // OBI response
  input  logic                      obi_gnt,
  input  logic                      obi_rvalid,
  input  logic [ARCHITECTURE-1:0]   obi_rdata,
  input  logic                      obi_err
);

  localparam int TOTAL   = VALUE_WIDTH + KEY_WIDTH + OP_WIDTH;
  localparam int NW      = (TOTAL + ARCHITECTURE - 1) / ARCHITECTURE;
  localparam int NR      = VALUE_WIDTH / ARCHITECTURE;
  localparam int FRAME_W = NW * ARCHITECTURE;
  localparam int IDX_W   = $clog2(NW + 1);
  localparam int TCNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BE_W    = ARCHITECTURE / 8;

  localparam logic [IDX_W-1:0]  LAST_WR   = IDX_W'(NW - 1);
  localparam logic [IDX_W-1:0]  LAST_RD   = IDX_W'(NR - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_REQ = 3'd1,
    S_WR_RSP = 3'd2,
    S_RD_REQ = 3'd3,
    S_RD_RSP = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [FRAME_W-1:0]  frame_q;
  logic [IDX_W-1:0]    idx_q;     // word index, shared by write and read phases
  logic [TCNT_W-1:0]   tcnt_q;    // cycles spent in the current wait state
  logic                tmo;       // current wait expires this cycle

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    obi_req    = 1'b0;
    obi_we     = 1'b0;
    obi_be     = '0;
    obi_addr   = '0;
    obi_wdata  = '0;
    obi_rready = 1'b0;
    tmo        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d = (cmd_op == '0) ? S_DONE : S_WR_REQ;
        end
      end

      S_WR_REQ: begin
        obi_req  = 1'b1;
        obi_we   = 1'b1;
        obi_be   = {BE_W{1'b1}};
        obi_addr = ARCHITECTURE'({idx_q, 2'b00});
        for (int i = 0; i < NW; i++) begin
          if (idx_q == IDX_W'(i)) begin
            obi_wdata = frame_q[i*ARCHITECTURE +: ARCHITECTURE];
          end
        end
        if (obi_gnt) begin
          state_d = S_WR_RSP;
        end else if (tcnt_q == TCNT_LAST) begin
          tmo     = 1'b1;
          state_d = S_DONE;
        end
      end

      S_WR_RSP: begin
        obi_rready = 1'b1;
        if (obi_rvalid) begin
          state_d = (idx_q == LAST_WR) ? S_RD_REQ : S_WR_REQ;
        end else if (tcnt_q == TCNT_LAST) begin
          tmo     = 1'b1;
          state_d = S_DONE;
        end
      end

      S_RD_REQ: begin
        obi_req  = 1'b1;
        obi_be   = {BE_W{1'b1}};
        obi_addr = ARCHITECTURE'({idx_q, 2'b00});
        // gnt is withheld while the cache processes the operation
        if (obi_gnt) begin
          state_d = S_RD_RSP;
        end else if (tcnt_q == TCNT_LAST) begin
          tmo     = 1'b1;
          state_d = S_DONE;
        end
      end

      S_RD_RSP: begin
        obi_rready = 1'b1;
        if (obi_rvalid) begin
          state_d = (idx_q == LAST_RD) ? S_DONE : S_RD_REQ;
        end else if (tcnt_q == TCNT_LAST) begin
          tmo     = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State register and datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      frame_q     <= '0;
      idx_q       <= '0;
      tcnt_q      <= '0;
      rsp_value   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q <= state_d;

      // Restart on every state entry; only the bus wait states accumulate.
      if ((state_d != state_q) || (state_q == S_IDLE) || (state_q == S_DONE)) begin
        tcnt_q <= '0;
      end else begin
        tcnt_q <= tcnt_q + TCNT_W'(1);
      end

      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            frame_q     <= FRAME_W'({cmd_op, cmd_key, cmd_value});
            idx_q       <= '0;
            rsp_value   <= '0;
            rsp_err     <= (cmd_op == '0);
            rsp_timeout <= 1'b0;
          end
        end

        S_WR_RSP: begin
          // write-response err is deliberately ignored
          if (obi_rvalid) begin
            idx_q <= (idx_q == LAST_WR) ? '0 : idx_q + IDX_W'(1);
          end
        end

        S_RD_RSP: begin
          if (obi_rvalid) begin
            for (int i = 0; i < NR; i++) begin
              if (idx_q == IDX_W'(i)) begin
                rsp_value[i*ARCHITECTURE +: ARCHITECTURE] <= obi_rdata;
              end
            end
            rsp_err <= rsp_err | obi_err;
            idx_q   <= (idx_q == LAST_RD) ? '0 : idx_q + IDX_W'(1);
          end
        end

        S_DONE: begin
          if (rsp_ready) begin
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
          end
        end

        default: ;
      endcase

      // Abort: keep captured words, flag both timeout and error.
      if (tmo) begin
        rsp_timeout <= 1'b1;
        rsp_err     <= 1'b1;
        idx_q       <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_obi_cache_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_obi_cache_master
// Purpose  : Self-checking bench for obi_cache_master. A simple OBI responder
//            grants/answers requests (with configurable grant stalls, error
//            injection and a never-grant mode); a table of directed vectors
//            and random commands are checked against expectations derived
//            from the frame layout and latency rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_obi_cache_master;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [28:0] cmd_key = '0;
  logic [63:0] cmd_value = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_value;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        obi_req, obi_we, obi_rready;
  logic [3:0]  obi_be;
  logic [31:0] obi_addr, obi_wdata;
  logic        obi_gnt = 1'b0, obi_rvalid = 1'b0, obi_err = 1'b0;
  logic [31:0] obi_rdata = '0;

  obi_cache_master #(
    .ARCHITECTURE(32), .KEY_WIDTH(29), .VALUE_WIDTH(64), .OP_WIDTH(3),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_key(cmd_key), .cmd_value(cmd_value),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_value(rsp_value),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .obi_req(obi_req), .obi_we(obi_we), .obi_be(obi_be), .obi_addr(obi_addr),
    .obi_wdata(obi_wdata), .obi_rready(obi_rready),
    .obi_gnt(obi_gnt), .obi_rvalid(obi_rvalid), .obi_rdata(obi_rdata),
    .obi_err(obi_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- OBI responder ----------------
  logic [31:0] rd_mem [2];
  int          err_word = -1;
  bit          wr_err = 1'b0;
  int          ws_left = 0, rs_left = 0;
  bit          never = 1'b0;
  bit          pending = 1'b0;
  bit          pend_we = 1'b0;
  int          pend_idx = 0;
  logic [68:0] log_q [$];   // {we, be, addr, wdata}

  always @(posedge clk) begin
    if (!rst_n) begin
      pending = 1'b0;
    end else if (obi_req && obi_gnt) begin
      pending  = 1'b1;
      pend_we  = obi_we;
      pend_idx = int'(obi_addr >> 2);
      log_q.push_back({obi_we, (obi_we ? obi_be : 4'hF), obi_addr, obi_wdata});
    end else if (pending && obi_rvalid && obi_rready) begin
      pending = 1'b0;
    end
  end

  always @(negedge clk) begin
    obi_gnt    = 1'b0;
    obi_rvalid = 1'b0;
    obi_rdata  = '0;
    obi_err    = 1'b0;
    if (pending) begin
      obi_rvalid = 1'b1;
      if (pend_we) begin
        obi_err = wr_err;
      end else begin
        if (pend_idx < 2) obi_rdata = rd_mem[pend_idx];
        obi_err = (pend_idx == err_word);
      end
    end else if (obi_req && !never) begin
      if (obi_we && ws_left > 0) ws_left--;
      else if (!obi_we && rs_left > 0) rs_left--;
      else obi_gnt = 1'b1;
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic [2:0]  op;
    logic [28:0] key;
    logic [63:0] value;
    logic [31:0] rd0, rd1;
    int          err_word;
    bit          werr;
    int          ws, rs;
    bit          never;
    logic [63:0] exp_value;
    bit          exp_err, exp_to;
    int          exp_lat;
  } vec_t;

  function automatic vec_t mk(logic [2:0] op, logic [28:0] key, logic [63:0] value,
                              logic [31:0] rd0, logic [31:0] rd1, int ew, bit werr,
                              int ws, int rs, bit nv);
    vec_t v;
    v.op = op; v.key = key; v.value = value; v.rd0 = rd0; v.rd1 = rd1;
    v.err_word = ew; v.werr = werr; v.ws = ws; v.rs = rs; v.never = nv;
    v.exp_value = '0; v.exp_err = 1'b0; v.exp_to = 1'b0; v.exp_lat = 0;
    return v;
  endfunction

  // Reference: what the response should be, from the protocol rules.
  function automatic vec_t model(vec_t v);
    vec_t r = v;
    if (v.op == 3'd0) begin
      r.exp_value = '0; r.exp_err = 1'b1; r.exp_to = 1'b0; r.exp_lat = 1;
    end else begin
      r.exp_value = {v.rd1, v.rd0};
      r.exp_err   = (v.err_word == 0) || (v.err_word == 1);
      r.exp_to    = 1'b0;
      r.exp_lat   = 1 + 2*3 + 2*2 + v.ws + v.rs;
    end
    return r;
  endfunction

  task automatic apply_cmd(input vec_t v);
    rd_mem[0] = v.rd0; rd_mem[1] = v.rd1;
    err_word = v.err_word; wr_err = v.werr;
    ws_left = v.ws; rs_left = v.rs; never = v.never;
    log_q.delete();
    @(negedge clk);
    cmd_op = v.op; cmd_key = v.key; cmd_value = v.value; cmd_valid = 1'b1;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int          cyc, reqcnt, hold_bad;
    logic [95:0] frame;
    logic [68:0] exp_q [$];
    logic [67:0] snap;
    apply_cmd(v);
    cyc = 0; reqcnt = 0;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (obi_req) reqcnt++;
      if (rsp_valid) break;
    end
    chk({nm, "_rsp_seen"}, rsp_valid, 1'b1);
    chk({nm, "_latency"}, cyc, v.exp_lat);
    chk({nm, "_value"}, rsp_value, v.exp_value);
    chk({nm, "_err_to"}, {rsp_err, rsp_timeout}, {v.exp_err, v.exp_to});
    if (v.never)           chk({nm, "_req_cycles"}, reqcnt, TMO);
    else if (v.op == 3'd0) chk({nm, "_req_cycles"}, reqcnt, 0);
    else                   chk({nm, "_req_cycles"}, reqcnt, 5 + v.ws + v.rs);

    // Hold the response: outputs stay put, no new command accepted.
    snap = {rsp_valid, cmd_ready, rsp_err, rsp_timeout, rsp_value};
    hold_bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if ({rsp_valid, cmd_ready, rsp_err, rsp_timeout, rsp_value} !== snap) hold_bad++;
    end
    chk({nm, "_hold_stable"}, hold_bad, 0);
    chk({nm, "_hold_cmd_ready"}, cmd_ready, 1'b0);

    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk({nm, "_back_idle"}, {rsp_valid, cmd_ready, rsp_err, rsp_timeout}, 4'b0100);

    // Bus traffic: frame words at 0/4/8, then value reads at 0/4.
    frame = {v.op, v.key, v.value};
    if (v.op != 3'd0 && !v.never) begin
      for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 4'hF, 32'(4*i), frame[i*32 +: 32]});
      for (int i = 0; i < 2; i++) exp_q.push_back({1'b0, 4'hF, 32'(4*i), 32'h0});
    end
    chk({nm, "_bus_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s_bus%0d", nm, i), log_q[i], exp_q[i]);
  endtask

  vec_t vecs [5];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t v;
    int   cyc;
    vecs[0] = mk(3'd1, 29'h0000_0ABC, 64'h1122_3344_5566_7788,
                 32'h5566_7788, 32'h1122_3344, -1, 1'b1, 0, 0, 1'b0);
    vecs[0].exp_value = 64'h1122_3344_5566_7788; vecs[0].exp_lat = 11;
    vecs[1] = mk(3'd2, 29'h5, 64'h0, 32'hDEAD_BEEF, 32'hCAFE_F00D, -1, 1'b0, 0, 7, 1'b0);
    vecs[1].exp_value = 64'hCAFE_F00D_DEAD_BEEF; vecs[1].exp_lat = 18;
    vecs[2] = mk(3'd2, 29'h1234, 64'h0, 32'hAAAA_5555, 32'h0F0F_0F0F, 1, 1'b0, 0, 0, 1'b0);
    vecs[2].exp_value = 64'h0F0F_0F0F_AAAA_5555; vecs[2].exp_err = 1'b1; vecs[2].exp_lat = 11;
    vecs[3] = mk(3'd0, 29'h7, 64'hFFFF_0000_FFFF_0000, 32'h1, 32'h2, -1, 1'b0, 0, 0, 1'b0);
    vecs[3].exp_err = 1'b1; vecs[3].exp_lat = 1;
    vecs[4] = mk(3'd3, 29'h1FFF_FFFF, 64'h0123_4567_89AB_CDEF, 32'h3, 32'h4, -1, 1'b0, 0, 0, 1'b1);
    vecs[4].exp_err = 1'b1; vecs[4].exp_to = 1'b1; vecs[4].exp_lat = 1 + TMO;

    // Reset state
    #12;
    chk("reset_outputs", {obi_req, obi_we, obi_be, obi_addr, obi_wdata, obi_rready,
                          cmd_ready, rsp_valid, rsp_err, rsp_timeout},
        {1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("reset_value", rsp_value, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Asynchronous reset in the middle of the second read word.
    v = vecs[0];
    apply_cmd(v);
    cyc = 0;
    while (log_q.size() < 5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_reached_rd_rsp", {obi_rready, log_q.size() >= 5}, 2'b11);
    chk("rst_pre_word0", rsp_value[31:0], v.rd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {obi_req, obi_rready, cmd_ready, rsp_valid, rsp_err, rsp_timeout},
        6'b001000);
    chk("rst_async_value", rsp_value, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec("after_rst", vecs[1]);

    // Random commands against the reference.
    for (int n = 0; n < 24; n++) begin
      logic [2:0] op;
      int         ew;
      op = ($urandom_range(0, 5) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      ew = int'($urandom_range(0, 3)) - 1;
      if (ew > 1) ew = -1;
      v = mk(op, 29'($urandom), {$urandom, $urandom}, $urandom, $urandom, ew,
             1'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 9)), 1'b0);
      v = model(v);
      run_vec($sformatf("rnd%0d", n), v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
